// File: rtl/clk_enable_pkg.sv
// Shared types and defaults for the multi-channel DDS clock-enable generator.
// Latency: n/a (declarations only); backpressure: n/a.
package clk_enable_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam int          DEF_NUM_CH     = 2;
    localparam int          DEF_ACC_W      = 24;
    localparam int          DEF_SETTLE_CYC = 1024;
    localparam int unsigned DEF_INC_RESET  = 32'd1 << 20;

    // Index width that stays at least one bit for single-entry ranges.
    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/clk_en_channel.sv
// One DDS tick channel with a shadowed increment that swaps on a period boundary.
// Latency: tick registered 1 cycle after carry; backpressure: pending blocks new writes until the swap.
module clk_en_channel #(
    parameter int               ACC_W    = 24,
    parameter logic [ACC_W-1:0] INC_INIT = '0
) (
    input  logic             clk_25MHz,
    input  logic             resetn,
    input  logic             run,
    input  logic             wr_en,
    input  logic [ACC_W-1:0] wr_inc,
    output logic             tick,
    output logic             pending
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W-1:0] shadow;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             apply;

    assign sum   = {1'b0, acc} + {1'b0, inc};
    assign carry = run & sum[ACC_W];
    // While running, swap only on a carry so the old period completes; a zero
    // increment never carries, and outside RUN there is no period to protect.
    assign apply = pending & (~run | carry | (inc == '0));

    always_ff @(posedge clk_25MHz or negedge resetn) begin
        if (!resetn) begin
            acc     <= '0;
            inc     <= INC_INIT;
            shadow  <= '0;
            pending <= 1'b0;
            tick    <= 1'b0;
        end else begin
            acc  <= run ? sum[ACC_W-1:0] : '0;
            tick <= carry;
            if (wr_en) begin
                shadow  <= wr_inc;
                pending <= 1'b1;
            end else if (apply) begin
                inc     <= shadow;
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_enable_generator.sv
// Multi-channel clock-enable source gated on a settled PLL lock, with run-time rate writes.
// Latency: RUN 3+SETTLE_CYC cycles after lock; backpressure: cfg_ready low while the addressed channel has a pending swap.
module clk_enable_generator
    import clk_enable_pkg::*;
#(
    parameter int          NUM_CH     = DEF_NUM_CH,
    parameter int          ACC_W      = DEF_ACC_W,
    parameter int          SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int unsigned INC_RESET  = DEF_INC_RESET
) (
    input  logic                        clk_25MHz,
    input  logic                        resetn,
    input  logic                        pll_lock,
    input  logic                        cfg_valid,
    input  logic [ch_w(NUM_CH)-1:0]     cfg_ch,
    input  logic [ACC_W-1:0]            cfg_inc,
    output logic                        cfg_ready,
    output logic [NUM_CH-1:0]           tick,
    output logic                        running
);

    localparam int               CH_W     = ch_w(NUM_CH);
    localparam int               CNT_W    = ch_w(SETTLE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

    logic              lock_meta;
    logic              lock_s;
    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              run;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] wr_en;

    always_ff @(posedge clk_25MHz or negedge resetn) begin
        if (!resetn) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge clk_25MHz or negedge resetn) begin
        if (!resetn) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            running <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= SETTLE;
                        cnt   <= '0;
                    end
                end
                SETTLE: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                    end else if (cnt == CNT_LAST) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state   <= WAIT_LOCK;
                        running <= 1'b0;
                    end
                end
                default: begin
                    state   <= WAIT_LOCK;
                    running <= 1'b0;
                end
            endcase
        end
    end

    // Dropping run in the lock-loss cycle clears accumulators and ticks on the
    // same edge that leaves RUN.
    assign run = running & lock_s;

    always_comb begin
        cfg_ready = 1'b1;
        wr_en     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~pending[i];
                wr_en[i]  = cfg_valid & ~pending[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_en_channel #(
            .ACC_W    (ACC_W),
            .INC_INIT (ACC_W'(INC_RESET))
        ) u_ch (
            .clk_25MHz (clk_25MHz),
            .resetn    (resetn),
            .run       (run),
            .wr_en     (wr_en[g]),
            .wr_inc    (cfg_inc),
            .tick      (tick[g]),
            .pending   (pending[g])
        );
    end

endmodule

// File: tb/tb_clk_enable_generator.sv
// Directed bench: lock sequencing, DDS rates, boundary-aligned rate swaps, lock loss and reset.
module tb_clk_enable_generator;

    logic       clk_25MHz = 1'b0;
    logic       resetn    = 1'b0;
    logic       pll_lock  = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ch    = 1'b0;
    logic [7:0] cfg_inc   = 8'd0;
    logic       cfg_ready;
    logic [1:0] tick;
    logic       running;

    logic       cfg3_valid = 1'b0;
    logic [1:0] cfg3_ch    = 2'd0;
    logic [7:0] cfg3_inc   = 8'd0;
    logic       cfg3_ready;
    logic [2:0] tick3;
    logic       running3;

    int total = 0;
    int bad   = 0;

    always #5 clk_25MHz = ~clk_25MHz;

    clk_enable_generator #(
        .NUM_CH(2), .ACC_W(8), .SETTLE_CYC(4), .INC_RESET(64)
    ) dut (
        .clk_25MHz (clk_25MHz),
        .resetn    (resetn),
        .pll_lock  (pll_lock),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_inc   (cfg_inc),
        .cfg_ready (cfg_ready),
        .tick      (tick),
        .running   (running)
    );

    clk_enable_generator #(
        .NUM_CH(3), .ACC_W(8), .SETTLE_CYC(4), .INC_RESET(64)
    ) dut3 (
        .clk_25MHz (clk_25MHz),
        .resetn    (resetn),
        .pll_lock  (pll_lock),
        .cfg_valid (cfg3_valid),
        .cfg_ch    (cfg3_ch),
        .cfg_inc   (cfg3_inc),
        .cfg_ready (cfg3_ready),
        .tick      (tick3),
        .running   (running3)
    );

    task automatic step();
        @(posedge clk_25MHz);
        #1;
    endtask

    task automatic wait_tick(input int ch, input int budget, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < budget && !ok) begin
            step();
            n++;
            if (tick[ch]) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        resetn   = 1'b0;
        pll_lock = 1'b1;
        repeat (3) step();
        total++; if (tick !== 2'b00) begin bad++; $display("FAIL rst_tick: got %b want 00", tick); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL rst_running: got %b want 0", running); end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL rst_cfg_ready: got %b want 1", cfg_ready); end
        resetn = 1'b1;
        repeat (6) step();
        total++; if (running !== 1'b0) begin bad++; $display("FAIL t1_running_early: got %b want 0", running); end
        step();
        total++; if (running !== 1'b1) begin bad++; $display("FAIL t1_running_rise: got %b want 1", running); end
        repeat (3) step();
        total++; if (tick !== 2'b00) begin bad++; $display("FAIL t1_pre_tick: got %b want 00", tick); end
        step();
        total++; if (tick !== 2'b11) begin bad++; $display("FAIL t1_first_tick: got %b want 11", tick); end
        repeat (3) step();
        total++; if (tick !== 2'b00) begin bad++; $display("FAIL t1_gap: got %b want 00", tick); end
        step();
        total++; if (tick !== 2'b11) begin bad++; $display("FAIL t1_second_tick: got %b want 11", tick); end
    endtask

    task automatic test_rate_change();
        int n;
        bit ok;
        wait_tick(0, 8, n, ok);
        total++; if (!ok) begin bad++; $display("FAIL t3_sync: got no tick want tick within 8"); end
        step();
        cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_inc = 8'd128;
        #1;
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL t3_ready_before: got %b want 1", cfg_ready); end
        step();
        cfg_valid = 1'b0;
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL t3_ready_pending: got %b want 0", cfg_ready); end
        step();
        total++; if (cfg_ready !== 1'b0 || tick[0] !== 1'b0) begin
            bad++; $display("FAIL t3_no_runt: got ready=%b tick0=%b want 0 0", cfg_ready, tick[0]); end
        step();
        total++; if (tick !== 2'b11 || cfg_ready !== 1'b1) begin
            bad++; $display("FAIL t3_boundary: got tick=%b ready=%b want 11 1", tick, cfg_ready); end
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (tick[0] !== 1'b0) begin bad++; $display("FAIL t3_new_gap%0d: got 1 want 0", k); end
            step();
            total++; if (tick[0] !== 1'b1) begin bad++; $display("FAIL t3_new_tick%0d: got 0 want 1", k); end
        end
    endtask

    task automatic test_extreme_inc();
        int n;
        bit ok;
        int gaps [4] = '{86, 85, 85, 86};
        int seen;
        cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_inc = 8'd3;
        step();
        cfg_valid = 1'b0;
        step();
        total++; if (tick[0] !== 1'b1) begin bad++; $display("FAIL t2_swap_tick: got 0 want 1"); end
        for (int k = 0; k < 4; k++) begin
            wait_tick(0, 100, n, ok);
            total++; if (!ok || n != gaps[k]) begin
                bad++; $display("FAIL t2_inc3_gap%0d: got %0d want %0d", k, ok ? n : -1, gaps[k]); end
        end
        wait_tick(1, 8, n, ok);
        cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_inc = 8'd0;
        step();
        cfg_valid = 1'b0;
        wait_tick(1, 8, n, ok);
        total++; if (!ok || n != 3) begin bad++; $display("FAIL t2_zero_swap: got %0d want 3", ok ? n : -1); end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL t2_zero_ready: got %b want 1", cfg_ready); end
        seen = 0;
        repeat (1000) begin
            step();
            if (tick[1]) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL t2_inc0_silent: got %0d ticks want 0", seen); end
        cfg_valid = 1'b1; cfg_inc = 8'd64;
        step();
        cfg_valid = 1'b0;
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL t2_inc0_pending: got %b want 0", cfg_ready); end
        step();
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL t2_inc0_swap_next: got %b want 1", cfg_ready); end
        wait_tick(1, 10, n, ok);
        total++; if (!ok || n != 4) begin bad++; $display("FAIL t2_restart_tick: got %0d want 4", ok ? n : -1); end
    endtask

    task automatic test_lock_drop();
        int n;
        int stray;
        int first0;
        int first1;
        bit ok;
        wait_tick(1, 8, n, ok);
        step();
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        step();
        total++; if (running !== 1'b1) begin bad++; $display("FAIL t4_running_hold: got %b want 1", running); end
        step();
        total++; if (running !== 1'b0 || tick !== 2'b00) begin
            bad++; $display("FAIL t4_stop: got running=%b tick=%b want 0 00", running, tick); end
        n = 0;
        stray = 0;
        while (running !== 1'b1 && n < 20) begin
            step();
            n++;
            if (tick !== 2'b00) stray++;
        end
        total++; if (n != 5) begin bad++; $display("FAIL t4_resettle: got %0d cycles want 5", n); end
        total++; if (stray != 0) begin bad++; $display("FAIL t4_ticks_stopped: got %0d ticks want 0", stray); end
        first0 = -1;
        first1 = -1;
        for (int s = 1; s <= 100; s++) begin
            step();
            if (tick[0] && first0 < 0) first0 = s;
            if (tick[1] && first1 < 0) first1 = s;
        end
        total++; if (first1 != 4) begin bad++; $display("FAIL t4_ch1_offset: got %0d want 4", first1); end
        total++; if (first0 != 86) begin bad++; $display("FAIL t4_ch0_offset: got %0d want 86", first0); end
    endtask

    task automatic test_settle_glitch();
        pll_lock = 1'b0;
        repeat (4) step();
        total++; if (running !== 1'b0) begin bad++; $display("FAIL t5_unlocked: got %b want 0", running); end
        pll_lock = 1'b1;
        repeat (3) step();
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        repeat (3) step();
        total++; if (running !== 1'b0) begin bad++; $display("FAIL t5_no_early_run: got %b want 0", running); end
        repeat (3) step();
        total++; if (running !== 1'b0) begin bad++; $display("FAIL t5_still_settling: got %b want 0", running); end
        step();
        total++; if (running !== 1'b1 || running3 !== 1'b1) begin
            bad++; $display("FAIL t5_run_delayed: got %b/%b want 1/1", running, running3); end
        cfg3_valid = 1'b1; cfg3_ch = 2'd3; cfg3_inc = 8'd128;
        #1;
        total++; if (cfg3_ready !== 1'b1) begin bad++; $display("FAIL t5_oob_ready: got %b want 1", cfg3_ready); end
        step();
        cfg3_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cfg3_ch = 2'(c);
            #1;
            total++; if (cfg3_ready !== 1'b1) begin bad++; $display("FAIL t5_oob_no_pending%0d: got %b want 1", c, cfg3_ready); end
        end
        step();
        step();
        total++; if (tick3 !== 3'b000) begin bad++; $display("FAIL t5_oob_gap: got %b want 000", tick3); end
        step();
        total++; if (tick3 !== 3'b111) begin bad++; $display("FAIL t5_oob_tick: got %b want 111", tick3); end
        repeat (3) step();
        total++; if (tick3 !== 3'b000) begin bad++; $display("FAIL t5_oob_gap2: got %b want 000", tick3); end
        step();
        total++; if (tick3 !== 3'b111) begin bad++; $display("FAIL t5_oob_tick2: got %b want 111", tick3); end
    endtask

    task automatic test_async_reset();
        int n;
        bit ok;
        cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_inc = 8'd128;
        step();
        cfg_valid = 1'b0;
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL t6_pending_set: got %b want 0", cfg_ready); end
        wait_tick(1, 8, n, ok);
        total++; if (!ok) begin bad++; $display("FAIL t6_sync: got no tick want tick within 8"); end
        #1 resetn = 1'b0;
        #1;
        total++; if (tick !== 2'b00 || running !== 1'b0) begin
            bad++; $display("FAIL t6_async_clear: got tick=%b running=%b want 00 0", tick, running); end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL t6_pending_dropped: got %b want 1", cfg_ready); end
        step();
        step();
        resetn = 1'b1;
        repeat (7) step();
        total++; if (running !== 1'b1) begin bad++; $display("FAIL t6_rerun: got %b want 1", running); end
        repeat (3) step();
        total++; if (tick !== 2'b00) begin bad++; $display("FAIL t6_pre_tick: got %b want 00", tick); end
        step();
        total++; if (tick !== 2'b11) begin bad++; $display("FAIL t6_inc_reset: got %b want 11", tick); end
        repeat (4) step();
        total++; if (tick !== 2'b11) begin bad++; $display("FAIL t6_period: got %b want 11", tick); end
    endtask

    initial begin
        test_reset();
        test_rate_change();
        test_extreme_inc();
        test_lock_drop();
        test_settle_glitch();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
